uart_tx_arb: RTL and testbench

Round-robin arbiter and sequencer that shares a single `uart_tx` transmitter between `NREQ` byte-stream requesters. It grants the transmitter to one requester for a whole message, ending with a byte flagged `last`. It issues one-cycle `wrEn` strobes to the transmitter and paces bytes off the transmitter's registered `busy` output. It sits between the system's message sources (debug, status and console producers) and the `uart_tx` instance.

---
 rtl/uart_tx_arb_if.sv | 19 +
 rtl/uart_tx_arb.sv | 110 +++++++++++
 tb/tb_uart_tx_arb.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester and transmitter signal bundle around the uart_tx arbiter
//   req/din/last : requester byte streams (valid, byte per requester, end-of-message)
//   ack/grant    : per-requester byte-taken pulse and one-hot current owner
//   txWrEn/txDin : write strobe and byte towards uart_tx
//   txBusy       : registered busy from uart_tx
//   err          : one-cycle pulse when txBusy never rose after a strobe
interface uart_tx_arb_if #(parameter int NREQ = 4);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] din;
    logic [NREQ-1:0]   last;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic              txWrEn;
    logic [7:0]        txDin;
    logic              txBusy;
    logic              err;
    modport master (input req, din, last, txBusy, output ack, grant, txWrEn, txDin, err);
    modport slave  (output req, din, last, txBusy, input ack, grant, txWrEn, txDin, err);
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin, message-locked sharing of one uart_tx among NREQ byte streams
//   clk, rst : clock and asynchronous active-high reset
//   bus      : master side of uart_tx_arb_if (requester handshake, uart_tx strobe/busy, err)
module uart_tx_arb #(
    parameter int NREQ    = 4,
    parameter int BUSY_TO = 8,
    parameter int GAP     = 0
) (
    input logic           clk,
    input logic           rst,
    uart_tx_arb_if.master bus
);
    localparam int IW = $clog2(NREQ);
    localparam logic [7:0] TO = 8'(BUSY_TO);
    localparam logic [7:0] GL = 8'(GAP);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_HI, WAIT_LO, GAP_S} state_t;
    state_t state, state_n;
    logic [IW-1:0] rr, rr_n, win, idx;
    logic found;
    logic [7:0] cnt, cnt_n, din_n;
    logic last_q, last_q_n, wr_n, err_n;
    logic [NREQ-1:0] ack_n, grant_n;

    // rr doubles as the owner index while a message is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr         <= IW'(NREQ - 1);
            cnt        <= '0;
            last_q     <= 1'b0;
            bus.ack    <= '0;
            bus.grant  <= '0;
            bus.txWrEn <= 1'b0;
            bus.txDin  <= '0;
            bus.err    <= 1'b0;
        end else begin
            state      <= state_n;
            rr         <= rr_n;
            cnt        <= cnt_n;
            last_q     <= last_q_n;
            bus.ack    <= ack_n;
            bus.grant  <= grant_n;
            bus.txWrEn <= wr_n;
            bus.txDin  <= din_n;
            bus.err    <= err_n;
        end
    end

    // first requester above the previous winner, wrapping
    always_comb begin
        found = 1'b0;
        win   = rr;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(rr) + k) % NREQ);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_n  = state;
        rr_n     = rr;
        cnt_n    = cnt;
        last_q_n = last_q;
        grant_n  = bus.grant;
        din_n    = bus.txDin;
        ack_n    = '0;
        wr_n     = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: if (found) begin
                grant_n = NREQ'(1) << win;
                rr_n    = win;
                state_n = LOAD;
            end
            LOAD: if (bus.req[rr]) begin
                wr_n     = 1'b1;
                din_n    = bus.din[{rr, 3'b000} +: 8];
                ack_n    = NREQ'(1) << rr;
                last_q_n = bus.last[rr];
                cnt_n    = '0;
                state_n  = WAIT_HI;
            end
            WAIT_HI: if (bus.txBusy) state_n = WAIT_LO;
            else begin
                cnt_n = cnt + 8'd1;
                if (cnt_n == TO) begin
                    err_n   = 1'b1;
                    grant_n = '0;
                    state_n = IDLE;
                end
            end
            WAIT_LO: if (!bus.txBusy) begin
                if (last_q) begin
                    grant_n = '0;
                    cnt_n   = '0;
                    state_n = (GAP == 0) ? IDLE : GAP_S;
                end else state_n = LOAD;
            end
            GAP_S: begin
                cnt_n = cnt + 8'd1;
                if (cnt_n == GL) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for uart_tx_arb with a behavioural uart_tx busy model
module tb_uart_tx_arb;
    localparam int NREQ = 4;
    localparam int BL = 10;
    typedef struct packed { logic [1:0] id; logic last; logic [7:0] b; } item_t;
    typedef struct packed { logic [3:0] g; logic [3:0] a; logic [7:0] b; } strobe_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arb_if #(.NREQ(NREQ)) bus();
    uart_tx_arb #(.NREQ(NREQ), .BUSY_TO(8), .GAP(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    item_t pend[$];
    strobe_t exp_s[$], obs_s[$];
    logic [3:0] exp_g[$], glog[$];
    int err_cyc[$];
    int compared = 0, mismatched = 0;
    int cyc = 0, dly = 0, bcnt = 0, multi = 0, last_strobe = 0;
    logic tie_low = 1'b0, mdl_clr = 1'b0;
    logic [3:0] stall = '0, prev_g = '0;

    // requester driver, uart_tx busy model (busy rises 3 edges after the strobe is seen) and monitor
    initial begin
        int k;
        bus.req = '0;
        bus.din = '0;
        bus.last = '0;
        bus.txBusy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mdl_clr) begin
                dly = 0;
                bcnt = 0;
                bus.txBusy = 1'b0;
            end else if (dly != 0) begin
                dly--;
                if (dly == 0 && !tie_low) begin
                    bus.txBusy = 1'b1;
                    bcnt = BL;
                end
            end else if (bcnt != 0) begin
                bcnt--;
                if (bcnt == 0) bus.txBusy = 1'b0;
            end
            if (bus.txWrEn === 1'b1) begin
                obs_s.push_back({bus.grant, bus.ack, bus.txDin});
                last_strobe = cyc;
                dly = 3;
            end
            if (bus.err === 1'b1) err_cyc.push_back(cyc);
            if (!$onehot0(bus.grant)) multi++;
            if (bus.grant != prev_g) begin
                if (bus.grant != '0) glog.push_back(bus.grant);
                prev_g = bus.grant;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ack[i] === 1'b1) begin
                    k = -1;
                    for (int j = 0; j < pend.size(); j++) if (k < 0 && int'(pend[j].id) == i) k = j;
                    if (k >= 0) pend.delete(k);
                end
            end
            bus.req = '0;
            for (int i = 0; i < NREQ; i++) begin
                for (int j = pend.size() - 1; j >= 0; j--) begin
                    if (int'(pend[j].id) == i) begin
                        bus.req[i] = !stall[i];
                        bus.din[8*i +: 8] = pend[j].b;
                        bus.last[i] = pend[j].last;
                    end
                end
            end
        end
    end

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(posedge clk);
            #2;
            ok = pend.size() == 0 && bus.grant == '0 && !bus.txBusy && dly == 0 && bcnt == 0;
        end
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        compared++;
        if (bus.grant !== 4'b0) begin mismatched++; $display("FAIL reset grant: got %b expected 0000", bus.grant); end
        compared++;
        if (bus.ack !== 4'b0) begin mismatched++; $display("FAIL reset ack: got %b expected 0000", bus.ack); end
        compared++;
        if (bus.txWrEn !== 1'b0) begin mismatched++; $display("FAIL reset txWrEn: got %b expected 0", bus.txWrEn); end
        compared++;
        if (bus.txDin !== 8'h00) begin mismatched++; $display("FAIL reset txDin: got %h expected 00", bus.txDin); end
        compared++;
        if (bus.err !== 1'b0) begin mismatched++; $display("FAIL reset err: got %b expected 0", bus.err); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic test_single;
        strobe_t e, o;
        logic [3:0] eg, og;
        bit ok;
        obs_s.delete(); glog.delete(); err_cyc.delete();
        pend.push_back({2'd2, 1'b0, 8'h41});
        pend.push_back({2'd2, 1'b1, 8'h42});
        exp_s.push_back({4'b0100, 4'b0100, 8'h41});
        exp_s.push_back({4'b0100, 4'b0100, 8'h42});
        exp_g.push_back(4'b0100);
        wait_done(400, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL single done: got timeout expected completion"); end
        while (exp_s.size() != 0) begin
            e = exp_s.pop_front();
            o = '0;
            if (obs_s.size() != 0) o = obs_s.pop_front();
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL single strobe grant/ack/byte: got %h expected %h", o, e); end
        end
        while (exp_g.size() != 0) begin
            eg = exp_g.pop_front();
            og = '0;
            if (glog.size() != 0) og = glog.pop_front();
            compared++;
            if (og !== eg) begin mismatched++; $display("FAIL single grant: got %b expected %b", og, eg); end
        end
        compared++;
        if (glog.size() + obs_s.size() + err_cyc.size() != 0) begin
            mismatched++;
            $display("FAIL single extras: got grants=%0d strobes=%0d errs=%0d expected 0", glog.size(), obs_s.size(), err_cyc.size());
        end
    endtask

    task automatic test_round_robin;
        strobe_t e, o;
        logic [3:0] eg, og;
        bit ok;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        obs_s.delete(); glog.delete();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                pend.push_back({2'(i), 1'b1, 8'(8'h10 + i)});
                exp_s.push_back({4'(1 << i), 4'(1 << i), 8'(8'h10 + i)});
                exp_g.push_back(4'(1 << i));
            end
            wait_done(500, ok);
            compared++;
            if (!ok) begin mismatched++; $display("FAIL rr done round %0d: got timeout expected completion", r); end
        end
        while (exp_s.size() != 0) begin
            e = exp_s.pop_front();
            o = '0;
            if (obs_s.size() != 0) o = obs_s.pop_front();
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL rr strobe grant/ack/byte: got %h expected %h", o, e); end
        end
        while (exp_g.size() != 0) begin
            eg = exp_g.pop_front();
            og = '0;
            if (glog.size() != 0) og = glog.pop_front();
            compared++;
            if (og !== eg) begin mismatched++; $display("FAIL rr grant order: got %b expected %b", og, eg); end
        end
    endtask

    task automatic test_lock;
        strobe_t e, o;
        logic [3:0] eg, og;
        bit ok;
        int n, z;
        obs_s.delete(); glog.delete();
        pend.push_back({2'd1, 1'b0, 8'h21});
        pend.push_back({2'd1, 1'b0, 8'h22});
        pend.push_back({2'd1, 1'b1, 8'h23});
        n = 0;
        while (bus.grant != 4'b0010 && n < 20) begin @(posedge clk); #2; n++; end
        pend.push_back({2'd0, 1'b1, 8'h05});
        for (int i = 1; i <= 3; i++) exp_s.push_back({4'b0010, 4'b0010, 8'(8'h20 + i)});
        exp_s.push_back({4'b0001, 4'b0001, 8'h05});
        exp_g.push_back(4'b0010);
        exp_g.push_back(4'b0001);
        n = 0;
        while (bus.grant == 4'b0010 && n < 500) begin @(posedge clk); #2; n++; end
        z = 0;
        while (bus.grant == 4'b0000 && z < 50) begin @(posedge clk); #2; z++; end
        compared++;
        if (z != 4) begin mismatched++; $display("FAIL lock gap cycles with grant 0: got %0d expected 4", z); end
        wait_done(400, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL lock done: got timeout expected completion"); end
        while (exp_s.size() != 0) begin
            e = exp_s.pop_front();
            o = '0;
            if (obs_s.size() != 0) o = obs_s.pop_front();
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL lock strobe grant/ack/byte: got %h expected %h", o, e); end
        end
        while (exp_g.size() != 0) begin
            eg = exp_g.pop_front();
            og = '0;
            if (glog.size() != 0) og = glog.pop_front();
            compared++;
            if (og !== eg) begin mismatched++; $display("FAIL lock grant order: got %b expected %b", og, eg); end
        end
    endtask

    task automatic test_stall;
        strobe_t e, o;
        bit ok, bad;
        int n;
        obs_s.delete(); glog.delete();
        pend.push_back({2'd3, 1'b0, 8'h31});
        pend.push_back({2'd3, 1'b0, 8'h32});
        pend.push_back({2'd3, 1'b1, 8'h33});
        n = 0;
        while (bus.grant != 4'b1000 && n < 20) begin @(posedge clk); #2; n++; end
        pend.push_back({2'd0, 1'b1, 8'h06});
        for (int i = 1; i <= 3; i++) exp_s.push_back({4'b1000, 4'b1000, 8'(8'h30 + i)});
        exp_s.push_back({4'b0001, 4'b0001, 8'h06});
        n = 0;
        while (obs_s.size() == 0 && n < 50) begin @(posedge clk); #2; n++; end
        stall[3] = 1'b1;
        n = 0;
        while (!bus.txBusy && n < 20) begin @(posedge clk); #2; n++; end
        while (bus.txBusy && n < 60) begin @(posedge clk); #2; n++; end
        bad = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #2;
            if (bus.grant != 4'b1000 || obs_s.size() != 1) bad = 1'b1;
        end
        compared++;
        if (bad) begin
            mismatched++;
            $display("FAIL stall hold: got grant=%b strobes=%0d expected grant=1000 strobes=1", bus.grant, obs_s.size());
        end
        stall[3] = 1'b0;
        wait_done(400, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL stall done: got timeout expected completion"); end
        while (exp_s.size() != 0) begin
            e = exp_s.pop_front();
            o = '0;
            if (obs_s.size() != 0) o = obs_s.pop_front();
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL stall strobe grant/ack/byte: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_timeout;
        strobe_t e, o;
        bit ok;
        int n;
        obs_s.delete(); glog.delete(); err_cyc.delete();
        tie_low = 1'b1;
        pend.push_back({2'd1, 1'b1, 8'h51});
        pend.push_back({2'd2, 1'b1, 8'h52});
        pend.push_back({2'd1, 1'b1, 8'h53});
        exp_s.push_back({4'b0010, 4'b0010, 8'h51});
        exp_s.push_back({4'b0100, 4'b0100, 8'h52});
        exp_s.push_back({4'b0010, 4'b0010, 8'h53});
        n = 0;
        while (err_cyc.size() == 0 && n < 100) begin @(posedge clk); #2; n++; end
        compared++;
        if (err_cyc.size() == 0 || err_cyc[0] - last_strobe != 8) begin
            mismatched++;
            $display("FAIL timeout err delay: got %0d expected 8", (err_cyc.size() == 0) ? -1 : err_cyc[0] - last_strobe);
        end
        compared++;
        if (bus.grant !== 4'b0000) begin mismatched++; $display("FAIL timeout grant release: got %b expected 0000", bus.grant); end
        tie_low = 1'b0;
        wait_done(400, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL timeout done: got timeout expected completion"); end
        compared++;
        if (err_cyc.size() != 1) begin mismatched++; $display("FAIL timeout err pulses: got %0d expected 1", err_cyc.size()); end
        while (exp_s.size() != 0) begin
            e = exp_s.pop_front();
            o = '0;
            if (obs_s.size() != 0) o = obs_s.pop_front();
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL timeout strobe grant/ack/byte: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_async_reset;
        strobe_t e, o;
        bit ok;
        int n;
        obs_s.delete(); glog.delete();
        pend.push_back({2'd2, 1'b0, 8'h61});
        pend.push_back({2'd2, 1'b1, 8'h62});
        exp_s.push_back({4'b0100, 4'b0100, 8'h61});
        n = 0;
        while (!bus.txBusy && n < 50) begin @(posedge clk); #2; n++; end
        repeat (3) @(posedge clk);
        #2;
        compared++;
        if (bus.grant !== 4'b0100) begin mismatched++; $display("FAIL areset pre grant: got %b expected 0100", bus.grant); end
        #3;
        rst = 1'b1;
        #1;
        compared++;
        if ({bus.grant, bus.ack, bus.txWrEn, bus.txDin, bus.err} !== 18'h0) begin
            mismatched++;
            $display("FAIL areset outputs: got grant=%b ack=%b wr=%b din=%h err=%b expected all 0",
                     bus.grant, bus.ack, bus.txWrEn, bus.txDin, bus.err);
        end
        mdl_clr = 1'b1;
        pend.delete();
        repeat (2) @(posedge clk);
        #5;
        rst = 1'b0;
        mdl_clr = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend.push_back({2'(i), 1'b1, 8'(8'h70 + i)});
            exp_s.push_back({4'(1 << i), 4'(1 << i), 8'(8'h70 + i)});
        end
        wait_done(500, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL areset done: got timeout expected completion"); end
        while (exp_s.size() != 0) begin
            e = exp_s.pop_front();
            o = '0;
            if (obs_s.size() != 0) o = obs_s.pop_front();
            compared++;
            if (o !== e) begin mismatched++; $display("FAIL areset strobe grant/ack/byte: got %h expected %h", o, e); end
        end
        compared++;
        if (multi != 0) begin mismatched++; $display("FAIL grant onehot: got %0d multi-hot cycles expected 0", multi); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_lock;
        test_stall;
        test_timeout;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
